// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check master.
// Holds the FSM encoding and the default expected ID words.
package sysid_check_pkg;

    localparam int unsigned STALL_W = 8;

    localparam logic [31:0] DEF_EXP_ID        = 32'h0000_0000;
    localparam logic [31:0] DEF_EXP_TIMESTAMP = 32'h5FB0_0F81;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the sysid slave (ID, timestamp)
// and compares both words against the expected build values.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXP_ID        = DEF_EXP_ID,
    parameter logic [31:0] EXP_TIMESTAMP = DEF_EXP_TIMESTAMP,
    parameter int unsigned TIMEOUT       = 255,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT - 1);

    state_t             state;
    logic [STALL_W-1:0] stall_cnt;
    logic               auto_pend;
    logic               stall_expired;

    // The stall that brings the counter up to TIMEOUT ends the read.
    assign stall_expired = avm_waitrequest && (stall_cnt == STALL_LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            stall_cnt   <= '0;
            auto_pend   <= AUTO_START;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done      <= 1'b0;
                    auto_pend <= 1'b0;
                    if (start || auto_pend) begin
                        state       <= ST_RD_ID;
                        stall_cnt   <= '0;
                        avm_address <= 1'b0;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                        id_value    <= '0;
                        ts_value    <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        stall_cnt   <= '0;
                        avm_address <= 1'b1;
                        state       <= ST_RD_TS;
                    end else if (stall_expired) begin
                        stall_cnt   <= stall_cnt + 1'b1;
                        timeout     <= 1'b1;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value    <= avm_readdata;
                        stall_cnt   <= '0;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        done        <= 1'b1;
                        id_mismatch <= (id_value != EXP_ID);
                        ts_mismatch <= (avm_readdata != EXP_TIMESTAMP);
                        pass        <= (id_value == EXP_ID) &&
                                       (avm_readdata == EXP_TIMESTAMP);
                        state       <= ST_DONE;
                    end else if (stall_expired) begin
                        stall_cnt   <= stall_cnt + 1'b1;
                        timeout     <= 1'b1;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: a zero/fixed-wait slave
// on the default instance plus a stuck-stall instance with TIMEOUT=4.
module tb_sysid_check_master;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass;
    logic        id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;

    logic        start2 = 1'b0;
    logic        avm_address2;
    logic        avm_read2;
    logic [31:0] avm_readdata2 = 32'hDEAD_BEEF;
    logic        avm_waitrequest2 = 1'b1;
    logic        busy2, done2, pass2;
    logic        id_mismatch2, ts_mismatch2, timeout2;
    logic [31:0] id_value2, ts_value2;

    logic [31:0] id_word = 32'h0000_0000;
    logic [31:0] ts_word = 32'h5FB0_0F81;
    int          wait_cfg = 0;
    int          wcnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sysid_check_master dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_mismatch     (id_mismatch),
        .ts_mismatch     (ts_mismatch),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    sysid_check_master #(
        .TIMEOUT    (4),
        .AUTO_START (1'b0)
    ) dut2 (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start2),
        .avm_address     (avm_address2),
        .avm_read        (avm_read2),
        .avm_readdata    (avm_readdata2),
        .avm_waitrequest (avm_waitrequest2),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .id_mismatch     (id_mismatch2),
        .ts_mismatch     (ts_mismatch2),
        .timeout         (timeout2),
        .id_value        (id_value2),
        .ts_value        (ts_value2)
    );

    // Slave model: each read stalls wait_cfg cycles, then completes.
    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read && (wcnt < wait_cfg);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wcnt <= 0;
        else if (!avm_read || !avm_waitrequest)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({avm_read, avm_address, busy, done, pass, id_mismatch,
             ts_mismatch, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {avm_read, avm_address, busy, done, pass,
                      id_mismatch, ts_mismatch, timeout});
        end
        checks++;
        if ({id_value, ts_value} !== 64'b0) begin
            errors++;
            $display("FAIL reset_values: got %h %h want 0 0",
                     id_value, ts_value);
        end
        checks++;
        if ({avm_read2, busy2, done2, timeout2} !== 4'b0) begin
            errors++;
            $display("FAIL reset_dut2: got %b want 0000",
                     {avm_read2, busy2, done2, timeout2});
        end
    endtask

    task automatic test_auto_start();
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({avm_read, avm_address, busy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL auto_rd_id: got %b want 1010",
                     {avm_read, avm_address, busy, done});
        end
        @(negedge clock);
        checks++;
        if ({avm_read, avm_address, busy, done} !== 4'b1110) begin
            errors++;
            $display("FAIL auto_rd_ts: got %b want 1110",
                     {avm_read, avm_address, busy, done});
        end
        @(negedge clock);
        checks++;
        if ({avm_read, busy, done, pass, id_mismatch, ts_mismatch,
             timeout} !== 7'b0111000) begin
            errors++;
            $display("FAIL auto_done: got %b want 0111000",
                     {avm_read, busy, done, pass, id_mismatch,
                      ts_mismatch, timeout});
        end
        checks++;
        if (id_value !== 32'h0 || ts_value !== 32'h5FB0_0F81) begin
            errors++;
            $display("FAIL auto_values: got %h %h want 0 5fb00f81",
                     id_value, ts_value);
        end
        @(negedge clock);
        checks++;
        if ({busy, done, pass} !== 3'b001) begin
            errors++;
            $display("FAIL auto_hold: got %b want 001",
                     {busy, done, pass});
        end
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL dut2_no_auto: got busy %b want 0", busy2);
        end
    endtask

    task automatic test_id_mismatch();
        int n;
        id_word = 32'h0000_0001;
        pulse_start();
        n = 1;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL idmm_latency: got %0d want 3", n);
        end
        checks++;
        if ({pass, id_mismatch, ts_mismatch, timeout} !== 4'b0100) begin
            errors++;
            $display("FAIL idmm_flags: got %b want 0100",
                     {pass, id_mismatch, ts_mismatch, timeout});
        end
        checks++;
        if (id_value !== 32'h1) begin
            errors++;
            $display("FAIL idmm_value: got %h want 1", id_value);
        end
        id_word = 32'h0;
        @(negedge clock);
    endtask

    task automatic test_wait_states();
        int  n;
        int  bad;
        logic prev_rd, prev_wr, prev_addr;
        logic saw0, saw1;
        bad = 0;
        saw0 = 1'b0;
        saw1 = 1'b0;
        wait_cfg = 3;
        pulse_start();
        n = 1;
        prev_rd = avm_read;
        prev_wr = avm_waitrequest;
        prev_addr = avm_address;
        while (!done && n < 30) begin
            if (avm_read && !avm_waitrequest) begin
                if (avm_address) saw1 = 1'b1;
                else saw0 = 1'b1;
            end
            @(negedge clock);
            n++;
            if (prev_rd && prev_wr &&
                (!avm_read || avm_address !== prev_addr))
                bad++;
            prev_rd = avm_read;
            prev_wr = avm_waitrequest;
            prev_addr = avm_address;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL wait_latency: got %0d want 9", n);
        end
        checks++;
        if (bad !== 0 || !saw0 || !saw1) begin
            errors++;
            $display("FAIL wait_stable: unstable %0d saw %b%b want 0 11",
                     bad, saw0, saw1);
        end
        checks++;
        if ({pass, timeout} !== 2'b10) begin
            errors++;
            $display("FAIL wait_pass: got %b want 10", {pass, timeout});
        end
        wait_cfg = 0;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int n;
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL to_latency: got %0d want 5", n);
        end
        checks++;
        if ({timeout2, pass2, avm_read2, id_mismatch2} !== 4'b1000) begin
            errors++;
            $display("FAIL to_flags: got %b want 1000",
                     {timeout2, pass2, avm_read2, id_mismatch2});
        end
        checks++;
        if (id_value2 !== 32'h0 || ts_value2 !== 32'h0) begin
            errors++;
            $display("FAIL to_values: got %h %h want 0 0",
                     id_value2, ts_value2);
        end
        @(negedge clock);
        checks++;
        if ({avm_read2, busy2, done2, timeout2} !== 4'b0001) begin
            errors++;
            $display("FAIL to_after: got %b want 0001",
                     {avm_read2, busy2, done2, timeout2});
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        pulses = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        if (done) pulses++;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses want 1",
                     pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, first, last;
        pulses = 0;
        first = -1;
        last = -1;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (done) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 3 || first !== 3 || last !== 11) begin
            errors++;
            $display("FAIL b2b: got %0d pulses at %0d..%0d want 3 at 3..11",
                     pulses, first, last);
        end
        repeat (4) @(negedge clock);
        checks++;
        if ({busy, pass} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_idle: got %b want 01", {busy, pass});
        end
    endtask

    task automatic test_reset_mid_read();
        int n, seen;
        seen = 0;
        pulse_start();
        checks++;
        if ({avm_read, avm_address, busy} !== 3'b101) begin
            errors++;
            $display("FAIL mid_in_rd_id: got %b want 101",
                     {avm_read, avm_address, busy});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({avm_read, avm_address, busy, done, pass, id_mismatch,
             ts_mismatch, timeout} !== 8'b0 ||
            {id_value, ts_value} !== 64'b0) begin
            errors++;
            $display("FAIL mid_async: got %b %h %h want 0",
                     {avm_read, avm_address, busy, done, pass,
                      id_mismatch, ts_mismatch, timeout},
                     id_value, ts_value);
        end
        repeat (2) begin
            @(negedge clock);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d pulses want 0", seen);
        end
        reset_n = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 3 || pass !== 1'b1) begin
            errors++;
            $display("FAIL mid_recover: got lat %0d pass %b want 3 1",
                     n, pass);
        end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_id_mismatch();
        test_wait_states();
        test_timeout();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_read();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_check_master.md
SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 The block SHALL have parameter EXP_ID, default 32'h0000_0000, meaning the expected system ID word at slave address 0.
REQ-002 The block SHALL have parameter EXP_TIMESTAMP, default 32'h5FB0_0F81, meaning the expected timestamp word at slave address 1.
REQ-003 The block SHALL have parameter TIMEOUT, default 255 (range 1..255), meaning the maximum number of waitrequest-stalled cycles per read.
REQ-004 The block SHALL have parameter AUTO_START, default 1, meaning that one check runs automatically after reset release.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: requests a check; sampled only in IDLE.
REQ-008 The block SHALL have port avm_address, output, 1 bit: Avalon-MM word address to the sysid slave.
REQ-009 The block SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-010 The block SHALL have port avm_readdata, input, 32 bits: slave read data, valid when avm_read=1 and avm_waitrequest=0.
REQ-011 The block SHALL have port avm_waitrequest, input, 1 bit: slave stall; tie to 0 for a zero-wait slave.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RD_ID, RD_TS and DONE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking check completion.
REQ-014 The block SHALL have port pass, output, 1 bit: check result, meaning both words matched and no timeout occurred.
REQ-015 The block SHALL have ports id_mismatch, ts_mismatch and timeout, each output, 1 bit: failure cause flags.
REQ-016 The block SHALL have ports id_value and ts_value, each output, 32 bits: the captured read words.

Function
REQ-017 The FSM SHALL have states IDLE, RD_ID, RD_TS and DONE.
REQ-018 IDLE SHALL go to RD_ID on start=1, or on the first cycle after reset release when AUTO_START=1.
REQ-019 Acceptance of a start SHALL clear pass, id_mismatch, ts_mismatch, timeout, id_value, ts_value and the stall counter.
REQ-020 In RD_ID the block SHALL drive avm_read=1 and avm_address=0; at the cycle where avm_waitrequest=0 it SHALL capture avm_readdata into id_value and go to RD_TS.
REQ-021 In RD_TS the block SHALL drive avm_read=1 and avm_address=1; at the cycle where avm_waitrequest=0 it SHALL capture ts_value and go to DONE.
REQ-022 avm_address and avm_read SHALL be held stable while avm_waitrequest=1; avm_read SHALL be 0 in IDLE and DONE.
REQ-023 An 8-bit stall counter SHALL increment each cycle of RD_ID or RD_TS with avm_waitrequest=1, and SHALL clear on each completed read.
REQ-024 When the stall counter reaches TIMEOUT, the block SHALL set timeout=1, drop avm_read the next cycle, and go to DONE, leaving any uncaptured value at 0.
REQ-025 On entry to DONE the block SHALL register the flags: id_mismatch=(id_value!=EXP_ID), ts_mismatch=(ts_value!=EXP_TIMESTAMP), skipped if timeout=1, and pass=!(id_mismatch|ts_mismatch|timeout).
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 All result outputs SHALL hold their values from DONE until the next accepted start.
REQ-028 With avm_waitrequest=0 and start at cycle N, the block SHALL issue reads at cycles N+1 and N+2 and assert done and valid results at N+3.
REQ-029 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-030 A start held high SHALL retrigger one cycle after DONE.

Reset
REQ-031 When reset_n=0, the block SHALL force state=IDLE and drive all outputs to 0 (avm_read, avm_address, busy, done, pass, flags, id_value, ts_value), regardless of clock.
REQ-032 A reset asserted mid-read SHALL abort the read with no done pulse; after release, the block SHALL behave per REQ-018.

Structure
REQ-033 Package sysid_check_pkg SHALL hold the state enum, the default EXP_ID/EXP_TIMESTAMP constants, and the stall-counter width (8).
REQ-034 The block SHALL be a single module with no sub-module; the compare and counter are inline.

Verification
REQ-035 Zero-wait slave returning 0 and then 32'h5FB0_0F81, AUTO_START=1 -> reads at addresses 0 and 1, done at the 3rd cycle after reset release, pass=1, all flags 0.
REQ-036 Slave returning 32'h0000_0001 at address 0 -> done with pass=0, id_mismatch=1, ts_mismatch=0, id_value=1.
REQ-037 avm_waitrequest=1 for 3 cycles on each read -> address and read held stable, done at start+9, pass=1.
REQ-038 avm_waitrequest stuck at 1, TIMEOUT=4 -> timeout=1, pass=0, avm_read low after DONE, id_value=0.
REQ-039 start pulsed during RD_TS -> ignored, exactly one done pulse; start held high -> back-to-back checks, one done per 4 cycles.
REQ-040 reset_n pulled low during RD_ID -> all outputs 0 immediately with no done pulse; after release, the auto check completes normally.
